// File: rtl/dmem_access_ctrl_pkg.sv
// Shared types for the data-memory access controller.
// Funct3 encodings and the access FSM state.
package dmem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_t;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } dmem_state_t;

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// Data-cache request/response bundle.
// master = access controller, slave = cache.
interface dmem_access_ctrl_if;

  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_read,
    output dmem_write,
    output dmem_address,
    output dmem_wmask,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_resp
  );

  modport slave (
    input  dmem_read,
    input  dmem_write,
    input  dmem_address,
    input  dmem_wmask,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_resp
  );

endinterface

// File: rtl/dmem_access_ctrl_store_align.sv
// Store lane alignment and misalignment detection.
// Shared by loads and stores: lw/sw and lh/sh use the same funct3.
module dmem_store_align
  import dmem_access_ctrl_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lsb,
  input  logic [31:0] i_store_data,
  output logic [3:0]  o_wmask,
  output logic [31:0] o_wdata,
  output logic        o_mis
);

  always_comb begin
    o_wmask = 4'b0000;
    o_mis   = 1'b0;
    o_wdata = i_store_data << {i_lsb, 3'b000};
    unique case (i_funct3)
      SB: o_wmask = 4'b0001 << i_lsb;
      SH, LHU: begin
        o_wmask = 4'b0011 << i_lsb;
        o_mis   = i_lsb[0];
      end
      SW: begin
        o_wmask = 4'b1111;
        o_mis   = |i_lsb;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data-cache sequencer: holds the request until resp,
// stalls the pipe, latches the raw load word for WB.
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic              op_load,
  input  logic              op_store,
  input  logic [2:0]        funct3,
  input  logic [31:0]       addr,
  input  logic [31:0]       store_data,
  input  logic              pipe_advance,
  input  logic              flush,
  dmem_access_ctrl_if.master dmem,
  output logic              mem_stall,
  output logic [31:0]       load_word,
  output logic [1:0]        load_lsb,
  output logic              misaligned,
  output logic [CNT_W-1:0]  stall_cycles
);

  dmem_state_t r_state, w_next;

  logic             r_read, r_write, r_drop, r_mis;
  logic [31:0]      r_addr, r_wdata, r_load_word;
  logic [3:0]       r_wmask;
  logic [1:0]       r_lsb, r_load_lsb;
  logic [CNT_W-1:0] r_cnt;

  logic        w_mem_op, w_start, w_mis, w_drop;
  logic [3:0]  w_wmask;
  logic [31:0] w_wdata;

  dmem_store_align u_align (
    .i_funct3     (funct3),
    .i_lsb        (addr[1:0]),
    .i_store_data (store_data),
    .o_wmask      (w_wmask),
    .o_wdata      (w_wdata),
    .o_mis        (w_mis)
  );

  assign w_mem_op = op_valid & (op_load | op_store) & ~flush;
  assign w_start  = w_mem_op & ~w_mis;
  assign w_drop   = r_drop | flush;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_stall = 1'b0;
    unique case (r_state)
      IDLE: begin
        mem_stall = w_start;
        if (w_start)       w_next = REQ;
        else if (w_mem_op) w_next = DONE;
      end
      REQ: begin
        mem_stall = 1'b1;
        if (dmem.dmem_resp) w_next = w_drop ? IDLE : DONE;
      end
      DONE: begin
        if (pipe_advance | flush) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_read      <= 1'b0;
      r_write     <= 1'b0;
      r_drop      <= 1'b0;
      r_mis       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wmask     <= '0;
      r_lsb       <= '0;
      r_load_word <= '0;
      r_load_lsb  <= '0;
      r_cnt       <= '0;
    end else begin
      if (r_state == IDLE && w_start) begin
        r_read  <= op_load;
        r_write <= op_store;
        r_addr  <= {addr[31:2], 2'b00};
        r_wmask <= op_store ? w_wmask : 4'b0000;
        r_wdata <= w_wdata;
        r_lsb   <= addr[1:0];
        r_drop  <= 1'b0;
      end
      if (r_state == IDLE && w_mem_op && w_mis) r_mis <= 1'b1;
      // a flushed op still finishes on the bus, but its result is discarded
      if (r_state == REQ) begin
        if (flush) r_drop <= 1'b1;
        if (dmem.dmem_resp) begin
          r_read  <= 1'b0;
          r_write <= 1'b0;
          if (!w_drop) begin
            if (r_read) r_load_word <= dmem.dmem_rdata;
            r_load_lsb <= r_lsb;
          end
        end
      end
      if (r_state == DONE && (pipe_advance | flush)) r_mis <= 1'b0;
      if (mem_stall && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign dmem.dmem_read    = r_read;
  assign dmem.dmem_write   = r_write;
  assign dmem.dmem_address = r_addr;
  assign dmem.dmem_wmask   = r_wmask;
  assign dmem.dmem_wdata   = r_wdata;
  assign load_word         = r_load_word;
  assign load_lsb          = r_load_lsb;
  assign misaligned        = r_mis;
  assign stall_cycles      = r_cnt;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table, corner sequences,
// and random ops against a transaction-level reference model.
module tb_dmem_access_ctrl;

  typedef struct {
    bit          ld;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    bit          fl;
  } op_t;

  typedef struct {
    bit          mis;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    int          stall;
    int          nrd;
    int          nwr;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  typedef struct {
    int          stall;
    int          nrd;
    int          nwr;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    bit          unstable;
    bit          mis_done;
    bit          mis_after;
    bit          req_after;
    bit          stall_after;
    bit          timeout;
  } obs_t;

  logic        clk = 0;
  logic        rst;
  logic        op_valid, op_load, op_store;
  logic [2:0]  funct3;
  logic [31:0] addr, store_data;
  logic        pipe_advance, flush;
  logic        mem_stall;
  logic [31:0] load_word;
  logic [1:0]  load_lsb;
  logic        misaligned;
  logic [31:0] stall_cycles;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_lw;
  logic [1:0]  m_lsb;
  int          m_total;

  dmem_access_ctrl_if dmem ();

  dmem_access_ctrl #(.CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .op_valid     (op_valid),
    .op_load      (op_load),
    .op_store     (op_store),
    .funct3       (funct3),
    .addr         (addr),
    .store_data   (store_data),
    .pipe_advance (pipe_advance),
    .flush        (flush),
    .dmem         (dmem),
    .mem_stall    (mem_stall),
    .load_word    (load_word),
    .load_lsb     (load_lsb),
    .misaligned   (misaligned),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic exp_t model(input op_t p);
    exp_t e;
    int   sz, off;
    e = '{default: 0};
    if (!(p.ld || p.st)) return e;
    sz    = acc_size(p.f3);
    off   = int'(p.a % 4);
    e.mis = (int'(p.a % sz) != 0);
    if (e.mis) return e;
    e.addr  = p.a - off;
    e.stall = p.dly + 1;
    e.nrd   = p.ld ? p.dly : 0;
    e.nwr   = p.st ? p.dly : 0;
    if (p.st) begin
      e.mask  = 4'(((1 << sz) - 1) << off);
      e.wdata = 32'(p.sd << (8 * off));
    end
    return e;
  endfunction

  task automatic do_txn(input op_t p, output obs_t o);
    bit rq, dropped, finished;
    int nreq;
    o = '{default: 0};
    nreq = 0;
    dropped = 0;
    finished = 0;
    @(negedge clk);
    op_valid = 1; op_load = p.ld; op_store = p.st;
    funct3 = p.f3; addr = p.a; store_data = p.sd;
    pipe_advance = 0; flush = 0; dmem.dmem_resp = 0;
    dmem.dmem_rdata = ~p.rd;
    for (int c = 0; c < 64; c++) begin
      rq = dmem.dmem_read | dmem.dmem_write;
      if (c > 0 && !rq) begin
        dmem.dmem_resp = 0;
        flush = 0;
        if (dropped) begin
          op_valid = 0;
          #1;
          o.mis_done    = misaligned;
          o.mis_after   = misaligned;
          o.req_after   = dmem.dmem_read | dmem.dmem_write;
          o.stall_after = mem_stall;
        end else begin
          pipe_advance = 1;
          #1;
          o.mis_done    = misaligned;
          o.stall_after = mem_stall;
          @(negedge clk);
          op_valid = 0;
          pipe_advance = 0;
          #1;
          o.mis_after   = misaligned;
          o.req_after   = dmem.dmem_read | dmem.dmem_write;
          o.stall_after = o.stall_after | mem_stall;
        end
        finished = 1;
        break;
      end
      if (rq) begin
        nreq++;
        if (nreq == 1) begin
          o.addr  = dmem.dmem_address;
          o.mask  = dmem.dmem_wmask;
          o.wdata = dmem.dmem_wdata;
        end else if (dmem.dmem_address != o.addr ||
                     dmem.dmem_wmask != o.mask ||
                     dmem.dmem_wdata != o.wdata) begin
          o.unstable = 1;
        end
      end
      dmem.dmem_resp  = rq && (nreq == p.dly);
      dmem.dmem_rdata = dmem.dmem_resp ? p.rd : ~p.rd;
      flush = rq && p.fl && (nreq == 1);
      if (flush) dropped = 1;
      #1;
      if (mem_stall) o.stall++;
      if (dmem.dmem_read) o.nrd++;
      if (dmem.dmem_write) o.nwr++;
      @(negedge clk);
    end
    if (!finished) o.timeout = 1;
    op_valid = 0; pipe_advance = 0; flush = 0; dmem.dmem_resp = 0;
  endtask

  task automatic run_check(input string nm, input op_t p, input exp_t e);
    obs_t o;
    do_txn(p, o);
    chk({nm, "_timeout"}, 64'(o.timeout), 0);
    chk({nm, "_stall"}, 64'(o.stall), 64'(e.stall));
    chk({nm, "_nrd"}, 64'(o.nrd), 64'(e.nrd));
    chk({nm, "_nwr"}, 64'(o.nwr), 64'(e.nwr));
    chk({nm, "_mis"}, 64'(o.mis_done), 64'(e.mis && !p.fl ? 1 : e.mis));
    chk({nm, "_mis_clr"}, 64'(o.mis_after), 0);
    chk({nm, "_reissue"}, 64'(o.req_after | o.stall_after), 0);
    chk({nm, "_stable"}, 64'(o.unstable), 0);
    if ((p.ld || p.st) && !e.mis) begin
      chk({nm, "_addr"}, 64'(o.addr), 64'(e.addr));
      chk({nm, "_wmask"}, 64'(o.mask), 64'(e.mask));
      if (p.st) chk({nm, "_wdata"}, 64'(o.wdata), 64'(e.wdata));
      if (!p.fl) begin
        if (p.ld) m_lw = p.rd;
        m_lsb = p.a[1:0];
      end
    end
    m_total += e.stall;
    chk({nm, "_load_word"}, 64'(load_word), 64'(m_lw));
    chk({nm, "_load_lsb"}, 64'(load_lsb), 64'(m_lsb));
    chk({nm, "_stall_cycles"}, 64'(stall_cycles), 64'(m_total));
  endtask

  vec_t tbl[14];

  initial begin
    op_t p;
    exp_t e;
    int lf3[5];
    lf3 = '{0, 1, 2, 4, 5};

    tbl[0]  = '{'{1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 3, 0},
                '{0, 32'h100, 4'h0, 32'h0, 4, 3, 0}};
    tbl[1]  = '{'{0, 1, 3'b000, 32'h203, 32'hAB, 0, 2, 0},
                '{0, 32'h200, 4'h8, 32'hAB000000, 3, 0, 2}};
    tbl[2]  = '{'{1, 0, 3'b001, 32'h101, 0, 32'h1, 1, 0},
                '{1, 0, 0, 0, 0, 0, 0}};
    tbl[3]  = '{'{0, 1, 3'b000, 32'h201, 32'h11, 0, 1, 0},
                '{0, 32'h200, 4'h2, 32'h00001100, 2, 0, 1}};
    tbl[4]  = '{'{0, 1, 3'b001, 32'h302, 32'hBEEF, 0, 1, 0},
                '{0, 32'h300, 4'hC, 32'hBEEF0000, 2, 0, 1}};
    tbl[5]  = '{'{0, 1, 3'b010, 32'h404, 32'h12345678, 0, 2, 0},
                '{0, 32'h404, 4'hF, 32'h12345678, 3, 0, 2}};
    tbl[6]  = '{'{1, 0, 3'b010, 32'h105, 0, 32'h2, 1, 0},
                '{1, 0, 0, 0, 0, 0, 0}};
    tbl[7]  = '{'{1, 0, 3'b101, 32'h107, 0, 32'h3, 1, 0},
                '{1, 0, 0, 0, 0, 0, 0}};
    tbl[8]  = '{'{0, 1, 3'b001, 32'h303, 32'h7777, 0, 1, 0},
                '{1, 0, 0, 0, 0, 0, 0}};
    tbl[9]  = '{'{1, 0, 3'b000, 32'h503, 0, 32'hA1B2C3D4, 1, 0},
                '{0, 32'h500, 4'h0, 32'h0, 2, 1, 0}};
    tbl[10] = '{'{1, 0, 3'b010, 32'h600, 0, 32'h55, 2, 1},
                '{0, 32'h600, 4'h0, 32'h0, 3, 2, 0}};
    tbl[11] = '{'{0, 0, 3'b010, 32'h800, 0, 32'h66, 1, 0},
                '{0, 0, 0, 0, 0, 0, 0}};
    tbl[12] = '{'{0, 1, 3'b010, 32'h700, 32'h99, 0, 1, 1},
                '{0, 32'h700, 4'hF, 32'h99, 2, 0, 1}};
    tbl[13] = '{'{0, 1, 3'b010, 32'h702, 32'h99, 0, 1, 0},
                '{1, 0, 0, 0, 0, 0, 0}};

    rst = 1; op_valid = 0; op_load = 0; op_store = 0; funct3 = 0;
    addr = 0; store_data = 0; pipe_advance = 0; flush = 0;
    dmem.dmem_resp = 0; dmem.dmem_rdata = 0;
    m_lw = 0; m_lsb = 0; m_total = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("reset_outputs", {dmem.dmem_read, dmem.dmem_write,
        dmem.dmem_address, dmem.dmem_wmask, misaligned, mem_stall}, 0);
    chk("reset_load", {load_word, load_lsb}, 0);
    chk("reset_cnt", 64'(stall_cycles), 0);

    for (int i = 0; i < 14; i++)
      run_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].e);

    // hold in DONE with pipe_advance low: no re-issue
    @(negedge clk);
    op_valid = 1; op_load = 1; op_store = 0; funct3 = 3'b010;
    addr = 32'h40; pipe_advance = 0;
    @(negedge clk);
    chk("hold_req", 64'(dmem.dmem_read), 1);
    dmem.dmem_resp = 1; dmem.dmem_rdata = 32'h0BADF00D;
    @(negedge clk);
    dmem.dmem_resp = 0; dmem.dmem_rdata = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hold_done%0d", k),
          {dmem.dmem_read, mem_stall}, 0);
      @(negedge clk);
    end
    pipe_advance = 1;
    @(negedge clk);
    op_valid = 0; pipe_advance = 0;
    m_total += 2; m_lw = 32'h0BADF00D; m_lsb = 0;
    #1;
    chk("hold_load_word", 64'(load_word), 64'(m_lw));
    chk("hold_cnt", 64'(stall_cycles), 64'(m_total));

    for (int i = 0; i < 40; i++) begin
      p.ld  = ($urandom_range(0, 1) == 1);
      p.st  = !p.ld && ($urandom_range(0, 7) != 0);
      p.f3  = p.st ? 3'($urandom_range(0, 2))
                   : 3'(lf3[$urandom_range(0, 4)]);
      p.a   = $urandom;
      p.sd  = $urandom;
      p.rd  = $urandom;
      p.dly = $urandom_range(1, 4);
      p.fl  = ($urandom_range(0, 4) == 0);
      e = model(p);
      run_check($sformatf("rnd%0d", i), p, e);
    end

    // reset during REQ, then a stray late response
    @(negedge clk);
    op_valid = 1; op_load = 1; op_store = 0; funct3 = 3'b000;
    addr = 32'h123;
    @(negedge clk);
    chk("rst_req", 64'(dmem.dmem_read), 1);
    rst = 1; op_valid = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rst_outputs", {dmem.dmem_read, dmem.dmem_write,
        dmem.dmem_address, dmem.dmem_wmask, misaligned, mem_stall}, 0);
    chk("rst_load", {load_word, load_lsb}, 0);
    chk("rst_cnt", 64'(stall_cycles), 0);
    dmem.dmem_resp = 1; dmem.dmem_rdata = 32'hCAFEBABE;
    @(negedge clk);
    dmem.dmem_resp = 0;
    @(negedge clk);
    #1;
    chk("late_resp", {load_word, load_lsb, mem_stall}, 0);
    chk("late_cnt", 64'(stall_cycles), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
